bsram_arbiter: RTL and testbench
================================

Name: bsram_arbiter

Overview:
- Owns the Gowin_SDPB 8 KB character/data BSRAM (port A write, port B read).
- After reset, clears the whole array to a fill value, then shares the single read port between two requesters:
  - the LCD character fetcher (real-time, priority);
  - the CPU (with a starvation guard).
- Forwards CPU writes to port A.
- Sits between cpu, lcd and bsram_inst in top.

Parameters:
- ADDR_W, 13, address width (8192 entries).
- DATA_W, 8, data width.
- READ_LATENCY, 1, cycles from the grant cycle to valid mem_dout (1 = bypass SDPB, 2 = pipeline SDPB). Legal values: 1 and 2 only.
- CPU_SLOT, 4, maximum consecutive LCD grants while a CPU read is pending.
- INIT_FILL, 8'h00, value written to every address during the clear.
- INIT_DEPTH, 8192, number of addresses cleared.

Ports:
- clk  in  1  system clock; drives clka/clkb of the BSRAM.
- rst  in  1  asynchronous, active-high reset.
- lcd_req  in  1  LCD read request, held until granted.
- lcd_addr  in  ADDR_W  LCD read address.
- lcd_gnt  out  1  LCD request accepted this cycle.
- lcd_rvalid  out  1  lcd_rdata valid.
- lcd_rdata  out  DATA_W  LCD read data.
- cpu_rreq  in  1  CPU read request, held until granted.
- cpu_raddr  in  ADDR_W  CPU read address.
- cpu_rgnt  out  1  CPU read accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_we  in  1  CPU write strobe.
- cpu_waddr  in  ADDR_W  CPU write address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_wready  out  1  write accepted when cpu_we && cpu_wready.
- init_done  out  1  clear finished; arbiter running.
- mem_cea  out  1  BSRAM port A write enable.
- mem_ada  out  ADDR_W  BSRAM write address.
- mem_din  out  DATA_W  BSRAM write data.
- mem_reseta  out  1  BSRAM port A reset.
- mem_ceb  out  1  BSRAM read enable.
- mem_adb  out  ADDR_W  BSRAM read address.
- mem_oce  out  1  BSRAM output clock enable.
- mem_resetb  out  1  BSRAM port B reset.
- mem_dout  in  DATA_W  BSRAM read data.

Behaviour:
- Single clock domain, clk. rst is asynchronous and active-high.

Reset values (all outputs 0 except the BSRAM resets):
- mem_reseta = 1, mem_resetb = 1.
- All gnt, rvalid, wready, init_done, mem_cea, mem_ceb = 0.
- Streak counter = 0; latency tag pipeline cleared.

FSM:
- RST_HOLD: keep mem_reseta/resetb = 1 for 2 cycles after rst deasserts, then go to CLEAR.
- CLEAR:
  - mem_cea = 1, mem_din = INIT_FILL, mem_ada = counter 0 .. INIT_DEPTH-1, one address per cycle.
  - No grants; cpu_wready = 0.
  - After address INIT_DEPTH-1 is written, go to RUN. The clear takes exactly INIT_DEPTH cycles.
- RUN:
  - init_done = 1 (registered; first RUN cycle).
  - mem_oce = 1.
  - cpu_wready = 1.
- rst at any point is asynchronous and returns the FSM to RST_HOLD:
  - In-flight reads are dropped; no rvalid is issued for them.
  - The clear restarts from address 0.

Writes (RUN):
- mem_cea = cpu_we, mem_ada = cpu_waddr, mem_din = cpu_wdata, combinationally.
- Accepted the same cycle; no arbitration.

Read arbitration (RUN, combinational grant, one grant per cycle max):
- Only lcd_req: LCD granted.
- Only cpu_rreq: CPU granted.
- Both requesting:
  - LCD granted unless streak == CPU_SLOT; in that case the CPU is granted.
  - streak counts consecutive LCD grants made while cpu_rreq is high.
  - It resets to 0 on any CPU grant or whenever cpu_rreq is low.
  - It saturates at CPU_SLOT.
- On a grant:
  - mem_ceb = 1.
  - mem_adb = address of the winner.
  - A tag {valid, is_cpu} enters a READ_LATENCY-deep shift register.
- With no grant: mem_ceb = 0 and mem_adb holds its last value.

Read return:
- The tag at the end of the shift register sets lcd_rvalid or cpu_rvalid for one cycle.
- This is exactly READ_LATENCY cycles after the gnt cycle.
- lcd_rdata = cpu_rdata = mem_dout. Data is valid only with the matching rvalid.
- Throughput is 1 read per cycle aggregate. Back-to-back grants are allowed.

Hazards:
- Write and read to the same address in the same cycle: the read returns the old data.
- A read granted on any later cycle returns the new data.
- No forwarding logic.

Decomposition:
- Package bsram_pkg holds:
  - ADDR_W and DATA_W constants;
  - state enum arb_state_t {RST_HOLD, CLEAR, RUN};
  - typedef rd_tag_t {logic valid; logic is_cpu;}.
- Sub-module bsram_rd_arbiter: two-requester priority with the streak counter. It is purely the grant logic plus counter.
- The FSM, clear counter and tag pipeline stay in bsram_arbiter.

Test Plan:
- Reset clear: rst pulse, INIT_DEPTH=16, INIT_FILL=8'hA5.
  - Required: mem_cea high 16 consecutive cycles, addresses 0..15, din A5.
  - Then init_done=1.
  - CPU read of address 7 returns 8'hA5 READ_LATENCY cycles after cpu_rgnt.
- Write/read:
  - CPU writes 8'h06 to 13'h0200.
  - Next cycle LCD reads 13'h0200 -> lcd_rvalid with lcd_rdata=8'h06 after 1 cycle (READ_LATENCY=1).
- Starvation guard:
  - lcd_req and cpu_rreq both held high, CPU_SLOT=4.
  - Required grant pattern LCD,LCD,LCD,LCD,CPU,LCD,...
  - cpu_rvalid appears exactly once per 5 grants.
- Latency 2: READ_LATENCY=2, alternating LCD/CPU grants every cycle.
  - Each rvalid arrives 2 cycles after its gnt, routed to the correct requester.
  - No missing or duplicate rvalids.
- Same-cycle hazard: address 13'h0010 holds 8'h11.
  - Write 8'h22 and CPU read of 13'h0010 in the same cycle -> 8'h11 returned.
  - A read on the next cycle -> 8'h22.
- Reset mid-operation:
  - Assert rst during CLEAR at address 5, and separately with a read in flight.
  - Required: no rvalid for the dropped read; all outputs return to reset values immediately.
  - The clear restarts at address 0.

Source files
------------

// File: rtl/bsram_pkg.sv
// Shared types and widths for the character/data BSRAM arbiter.
package bsram_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    RST_HOLD,
    CLEAR,
    RUN
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic is_cpu;
  } rd_tag_t;

endpackage

// File: rtl/bsram_rd_arbiter.sv
// Two-requester read-port arbiter: LCD has priority, the CPU is guaranteed a
// slot after CPU_SLOT consecutive LCD wins while it waits.
module bsram_rd_arbiter #(
  parameter int CPU_SLOT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic lcd_req,
  input  logic cpu_req,
  output logic lcd_gnt,
  output logic cpu_gnt
);

  localparam int SW = $clog2(CPU_SLOT + 1);

  logic [SW-1:0] streak_q;
  logic          cpu_due;

  assign cpu_due = (streak_q == SW'(CPU_SLOT));
  assign lcd_gnt = en && lcd_req && !(cpu_req && cpu_due);
  assign cpu_gnt = en && cpu_req && !lcd_gnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (!en || !cpu_req || cpu_gnt) begin
      streak_q <= '0;
    end else if (lcd_gnt && !cpu_due) begin
      streak_q <= streak_q + 1'b1;
    end
  end

endmodule

// File: rtl/bsram_arbiter.sv
// Owns the SDPB character BSRAM: clears it after reset, forwards CPU writes to
// port A and shares read port B between the LCD fetcher and the CPU.
module bsram_arbiter
  import bsram_pkg::*;
#(
  parameter int                   ADDR_W       = bsram_pkg::ADDR_W,
  parameter int                   DATA_W       = bsram_pkg::DATA_W,
  parameter int                   READ_LATENCY = 1,
  parameter int                   CPU_SLOT     = 4,
  parameter logic [DATA_W-1:0]    INIT_FILL    = 8'h00,
  parameter int                   INIT_DEPTH   = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_req,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic              lcd_gnt,
  output logic              lcd_rvalid,
  output logic [DATA_W-1:0] lcd_rdata,
  input  logic              cpu_rreq,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic              cpu_rgnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wready,
  output logic              init_done,
  output logic              mem_cea,
  output logic [ADDR_W-1:0] mem_ada,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_reseta,
  output logic              mem_ceb,
  output logic [ADDR_W-1:0] mem_adb,
  output logic              mem_oce,
  output logic              mem_resetb,
  input  logic [DATA_W-1:0] mem_dout
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bsram_arbiter: READ_LATENCY must be 1 or 2");
  end

  arb_state_t        state_q, state_d;
  logic              hold_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] adb_q;
  logic              init_done_q;
  logic              run;
  logic              lcd_gnt_w, cpu_gnt_w;
  rd_tag_t           tag_q [READ_LATENCY];

  assign run = (state_q == RUN);

  bsram_rd_arbiter #(
    .CPU_SLOT (CPU_SLOT)
  ) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .lcd_req (lcd_req),
    .cpu_req (cpu_rreq),
    .lcd_gnt (lcd_gnt_w),
    .cpu_gnt (cpu_gnt_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_HOLD;
      hold_q      <= 1'b0;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= (state_q == RST_HOLD) && !hold_q;
      clr_cnt_q   <= (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
      init_done_q <= (state_d == RUN);
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mem_cea = 1'b0;
    mem_ada = '0;
    mem_din = '0;
    unique case (state_q)
      RST_HOLD: begin
        if (hold_q) state_d = CLEAR;
      end
      CLEAR: begin
        mem_cea = 1'b1;
        mem_ada = clr_cnt_q;
        mem_din = INIT_FILL;
        if (clr_cnt_q == ADDR_W'(INIT_DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        mem_cea = cpu_we;
        mem_ada = cpu_waddr;
        mem_din = cpu_wdata;
      end
      default: state_d = RST_HOLD;
    endcase
  end

  assign mem_reseta = (state_q == RST_HOLD);
  assign mem_resetb = (state_q == RST_HOLD);
  assign mem_oce    = run;
  assign cpu_wready = run;
  assign init_done  = init_done_q;

  assign lcd_gnt  = lcd_gnt_w;
  assign cpu_rgnt = cpu_gnt_w;
  assign mem_ceb  = lcd_gnt_w || cpu_gnt_w;
  assign mem_adb  = lcd_gnt_w ? lcd_addr : (cpu_gnt_w ? cpu_raddr : adb_q);

  // NOTE: the tag pipeline is reset so in-flight reads vanish with rst; the
  // BSRAM array has no reset and is scrubbed by the CLEAR sweep instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adb_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      adb_q    <= mem_adb;
      tag_q[0] <= '{valid: mem_ceb, is_cpu: cpu_gnt_w};
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign lcd_rvalid = tag_q[READ_LATENCY-1].valid && !tag_q[READ_LATENCY-1].is_cpu;
  assign cpu_rvalid = tag_q[READ_LATENCY-1].valid &&  tag_q[READ_LATENCY-1].is_cpu;
  assign lcd_rdata  = mem_dout;
  assign cpu_rdata  = mem_dout;

endmodule

// File: tb/tb_bsram_arbiter.sv
// Drives a latency-1 and a latency-2 arbiter with identical stimulus, each with
// its own SDPB model, and checks both against a cycle-level reference model.
module tb_bsram_arbiter;

  localparam int          DEPTH = 16;
  localparam logic [7:0]  FILL  = 8'hA5;
  localparam int          SLOT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_req, cpu_rreq, cpu_we;
  logic [12:0] lcd_addr, cpu_raddr, cpu_waddr;
  logic [7:0]  cpu_wdata;

  logic        lcd_gnt [2], lcd_rvalid [2], cpu_rgnt [2], cpu_rvalid [2];
  logic [7:0]  lcd_rdata [2], cpu_rdata [2], mem_din [2], mem_dout [2];
  logic        cpu_wready [2], init_done [2], mem_cea [2], mem_reseta [2];
  logic        mem_ceb [2], mem_oce [2], mem_resetb [2];
  logic [12:0] mem_ada [2], mem_adb [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bsram_arbiter #(
      .READ_LATENCY (g + 1),
      .CPU_SLOT     (SLOT),
      .INIT_FILL    (FILL),
      .INIT_DEPTH   (DEPTH)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .lcd_req    (lcd_req),
      .lcd_addr   (lcd_addr),
      .lcd_gnt    (lcd_gnt[g]),
      .lcd_rvalid (lcd_rvalid[g]),
      .lcd_rdata  (lcd_rdata[g]),
      .cpu_rreq   (cpu_rreq),
      .cpu_raddr  (cpu_raddr),
      .cpu_rgnt   (cpu_rgnt[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .cpu_we     (cpu_we),
      .cpu_waddr  (cpu_waddr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wready (cpu_wready[g]),
      .init_done  (init_done[g]),
      .mem_cea    (mem_cea[g]),
      .mem_ada    (mem_ada[g]),
      .mem_din    (mem_din[g]),
      .mem_reseta (mem_reseta[g]),
      .mem_ceb    (mem_ceb[g]),
      .mem_adb    (mem_adb[g]),
      .mem_oce    (mem_oce[g]),
      .mem_resetb (mem_resetb[g]),
      .mem_dout   (mem_dout[g])
    );
  end

  // SDPB models: instance 0 bypass output, instance 1 pipelined output.
  logic [7:0] bmem [2][8192];
  logic [7:0] q1 [2], q2 [2];
  bit         bm_init = 0;

  always @(posedge clk) begin
    if (!bm_init) begin
      for (int a = 0; a < 8192; a++) begin
        bmem[0][a] = 8'h00;
        bmem[1][a] = 8'h00;
      end
      bm_init = 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (mem_ceb[i]) q1[i] <= bmem[i][mem_adb[i]];
      if (mem_oce[i]) q2[i] <= q1[i];
      if (mem_cea[i]) bmem[i][mem_ada[i]] = mem_din[i];
    end
  end

  assign mem_dout[0] = q1[0];
  assign mem_dout[1] = q2[1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_reseta%0d", tag, i), mem_reseta[i], 1);
      check($sformatf("%s_resetb%0d", tag, i), mem_resetb[i], 1);
      check($sformatf("%s_cea%0d", tag, i), mem_cea[i], 0);
      check($sformatf("%s_ceb%0d", tag, i), mem_ceb[i], 0);
      check($sformatf("%s_ada%0d", tag, i), mem_ada[i], 0);
      check($sformatf("%s_adb%0d", tag, i), mem_adb[i], 0);
      check($sformatf("%s_gnt%0d", tag, i), {lcd_gnt[i], cpu_rgnt[i]}, 0);
      check($sformatf("%s_rv%0d", tag, i), {lcd_rvalid[i], cpu_rvalid[i]}, 0);
      check($sformatf("%s_wrdy%0d", tag, i), cpu_wready[i], 0);
      check($sformatf("%s_done%0d", tag, i), init_done[i], 0);
      check($sformatf("%s_oce%0d", tag, i), mem_oce[i], 0);
    end
  endtask

  // Reference model: phase from cycles since reset release, a wait counter for
  // the CPU, a golden memory image and a list of expected read returns.
  typedef struct {
    int         due;
    int         dut;
    bit         is_cpu;
    logic [7:0] data;
  } ret_t;

  ret_t        exp_q [$];
  logic [7:0]  ref_mem [8192];
  int          cyc = 0;
  int          k = 0;
  int          cpu_wait = 0;
  int          j;
  logic [12:0] last_adb = '0;
  bit          hold_ph, clr_ph, run_ph, exp_l, exp_c;
  bit          exp_lv [2], exp_cv [2];
  logic [7:0]  exp_d [2];

  always @(negedge clk) begin
    if (cyc == 0) for (int a = 0; a < 8192; a++) ref_mem[a] = 8'h00;
    cyc++;
    if (rst) begin
      k        = 0;
      cpu_wait = 0;
      last_adb = '0;
      exp_q.delete();
      check_reset_vals("mon_rst");
    end else begin
      hold_ph = (k < 2);
      clr_ph  = (k >= 2) && (k < 2 + DEPTH);
      run_ph  = !hold_ph && !clr_ph;
      for (int i = 0; i < 2; i++) begin
        exp_lv[i] = 0;
        exp_cv[i] = 0;
        exp_d[i]  = '0;
      end
      j = 0;
      while (j < exp_q.size()) begin
        if (exp_q[j].due == cyc) begin
          if (exp_q[j].is_cpu) exp_cv[exp_q[j].dut] = 1;
          else                 exp_lv[exp_q[j].dut] = 1;
          exp_d[exp_q[j].dut] = exp_q[j].data;
          exp_q.delete(j);
        end else begin
          j++;
        end
      end
      exp_l = run_ph && lcd_req && !(cpu_rreq && cpu_wait >= SLOT);
      exp_c = run_ph && cpu_rreq && !exp_l;
      if (exp_l)      last_adb = lcd_addr;
      else if (exp_c) last_adb = cpu_raddr;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("lrv%0d", i), lcd_rvalid[i], exp_lv[i]);
        check($sformatf("crv%0d", i), cpu_rvalid[i], exp_cv[i]);
        if (exp_lv[i]) check($sformatf("lrd%0d", i), lcd_rdata[i], exp_d[i]);
        if (exp_cv[i]) check($sformatf("crd%0d", i), cpu_rdata[i], exp_d[i]);
        check($sformatf("rsta%0d", i), {mem_reseta[i], mem_resetb[i]}, {hold_ph, hold_ph});
        check($sformatf("done%0d", i), init_done[i], run_ph);
        check($sformatf("wrdy%0d", i), cpu_wready[i], run_ph);
        check($sformatf("oce%0d", i), mem_oce[i], run_ph);
        check($sformatf("lgnt%0d", i), lcd_gnt[i], exp_l);
        check($sformatf("cgnt%0d", i), cpu_rgnt[i], exp_c);
        check($sformatf("ceb%0d", i), mem_ceb[i], exp_l || exp_c);
        check($sformatf("adb%0d", i), mem_adb[i], last_adb);
        if (clr_ph) begin
          check($sformatf("clr_cea%0d", i), mem_cea[i], 1);
          check($sformatf("clr_ada%0d", i), mem_ada[i], k - 2);
          check($sformatf("clr_din%0d", i), mem_din[i], FILL);
        end else if (run_ph) begin
          check($sformatf("wr_cea%0d", i), mem_cea[i], cpu_we);
          check($sformatf("wr_ada%0d", i), mem_ada[i], cpu_waddr);
          check($sformatf("wr_din%0d", i), mem_din[i], cpu_wdata);
        end else begin
          check($sformatf("hold_cea%0d", i), mem_cea[i], 0);
        end
        if (exp_l || exp_c)
          exp_q.push_back('{due: cyc + i + 1, dut: i, is_cpu: exp_c,
                            data: ref_mem[exp_l ? lcd_addr : cpu_raddr]});
      end
      if (clr_ph)                ref_mem[k-2] = FILL;
      else if (run_ph && cpu_we) ref_mem[cpu_waddr] = cpu_wdata;
      cpu_wait = (cpu_rreq && exp_l) ? cpu_wait + 1 : 0;
      k++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (init_done[0] && init_done[1]) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int  n_cea, cnt;
    bit  found, lg, cg;
    lcd_req = 0; cpu_rreq = 0; cpu_we = 0;
    lcd_addr = '0; cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Clear sweep: 16 consecutive writes of the fill value, then init_done.
    n_cea = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_cea[0]) begin
        check("clr_seq_addr", mem_ada[0], n_cea);
        check("clr_seq_din", mem_din[0], 8'hA5);
        n_cea++;
      end
      if (init_done[0]) break;
    end
    check("clr_len", n_cea, 16);
    check("init_done", init_done[0], 1);

    // CPU read of a cleared address.
    tick();
    cpu_rreq = 1; cpu_raddr = 13'd7;
    @(negedge clk); check("rd7_gnt", cpu_rgnt[0], 1);
    tick(); cpu_rreq = 0;
    @(negedge clk); check("rd7_rv", cpu_rvalid[0], 1); check("rd7_data", cpu_rdata[0], 8'hA5);

    // Write then LCD read on the following cycle.
    tick(); cpu_we = 1; cpu_waddr = 13'h0200; cpu_wdata = 8'h06;
    tick(); cpu_we = 0; lcd_req = 1; lcd_addr = 13'h0200;
    @(negedge clk); check("wr_lcd_gnt", lcd_gnt[0], 1);
    tick(); lcd_req = 0;
    @(negedge clk); check("wr_lcd_rv", lcd_rvalid[0], 1); check("wr_lcd_data", lcd_rdata[0], 8'h06);

    // Same-cycle write/read hazard returns old data; next-cycle read sees new.
    tick(); cpu_we = 1; cpu_waddr = 13'h0010; cpu_wdata = 8'h11;
    tick(); cpu_wdata = 8'h22; cpu_rreq = 1; cpu_raddr = 13'h0010;
    @(negedge clk); check("haz_gnt0", cpu_rgnt[0], 1);
    tick(); cpu_we = 0;
    @(negedge clk); check("haz_gnt1", cpu_rgnt[0], 1);
    check("haz_old_rv", cpu_rvalid[0], 1); check("haz_old", cpu_rdata[0], 8'h11);
    tick(); cpu_rreq = 0;
    @(negedge clk); check("haz_new_rv", cpu_rvalid[0], 1); check("haz_new", cpu_rdata[0], 8'h22);

    // Starvation guard: LLLLC pattern with both requests held.
    tick(); lcd_req = 1; cpu_rreq = 1; lcd_addr = 13'd3; cpu_raddr = 13'h0200;
    cnt = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20) begin
        check($sformatf("starve_cgnt%0d", i), cpu_rgnt[0], (i % 5) == 4);
        check($sformatf("starve_lgnt%0d", i), lcd_gnt[0], (i % 5) != 4);
      end
      if (i >= 1 && cpu_rvalid[0]) cnt++;
      tick();
      if (i == 19) begin lcd_req = 0; cpu_rreq = 0; end
    end
    check("starve_cpu_rv_cnt", cnt, 4);

    // Latency 2: alternating grants, each return exactly two cycles later.
    tick();
    lcd_req = 1; cpu_rreq = 0; lcd_addr = 13'd0; cpu_raddr = 13'd0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 12) begin
        check($sformatf("l2_lgnt%0d", i), lcd_gnt[1], (i % 2) == 0);
        check($sformatf("l2_cgnt%0d", i), cpu_rgnt[1], (i % 2) == 1);
      end
      check($sformatf("l2_lrv%0d", i), lcd_rvalid[1], i >= 2 && (i - 2) % 2 == 0);
      check($sformatf("l2_crv%0d", i), cpu_rvalid[1], i >= 2 && (i - 2) % 2 == 1);
      tick();
      lcd_req   = (i + 1 < 12) && ((i + 1) % 2 == 0);
      cpu_rreq  = (i + 1 < 12) && ((i + 1) % 2 == 1);
      lcd_addr  = 13'(i + 1);
      cpu_raddr = 13'(i + 1);
    end

    // Randomised traffic; requests are held until granted.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      lg = lcd_gnt[0];
      cg = cpu_rgnt[0];
      tick();
      if (!lcd_req || lg) begin
        lcd_req  = ($urandom_range(0, 3) != 0);
        lcd_addr = 13'($urandom_range(0, 31));
      end
      if (!cpu_rreq || cg) begin
        cpu_rreq  = ($urandom_range(0, 1) != 0);
        cpu_raddr = 13'($urandom_range(0, 31));
      end
      cpu_we    = ($urandom_range(0, 3) == 0);
      cpu_waddr = 13'($urandom_range(0, 31));
      cpu_wdata = 8'($urandom);
    end
    tick();
    lcd_req = 0; cpu_rreq = 0; cpu_we = 0;

    // Reset during the clear at address 5; the sweep restarts from 0.
    #2 rst = 1;
    #1 check_reset_vals("rst_run");
    tick(); rst = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_cea[0] && mem_ada[0] == 13'd5) begin
        found = 1;
        break;
      end
    end
    check("clr5_seen", found, 1);
    #2 rst = 1;
    #1 check_reset_vals("rst_clr");
    tick(); rst = 0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_cea[0]) begin
        check("restart_addr0", mem_ada[0], 0);
        found = 1;
        break;
      end
    end
    check("restart_seen", found, 1);
    wait_init("init_after_clr_rst");

    // Reset with a latency-2 read in flight: its rvalid must never appear.
    tick(); cpu_rreq = 1; cpu_raddr = 13'd7;
    @(negedge clk); check("inflight_gnt", cpu_rgnt[1], 1);
    tick(); cpu_rreq = 0;
    #2 rst = 1;
    #1 check_reset_vals("rst_rd");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("drop_rv%0d", c), cpu_rvalid[1], 0);
    end
    tick(); rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("drop_post_rv%0d", c), {cpu_rvalid[1], lcd_rvalid[1]}, 0);
    end
    wait_init("init_after_rd_rst");
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
